// File: rtl/md_unit.sv
// Multi-cycle mult/multu/div/divu unit owning the HI/LO registers; also serves mthi/mtlo/mfhi/mflo.
// Latency: result commits MULT_CYCLES/DIV_CYCLES edges after launch; busy is high for exactly that many cycles.
// Backpressure: start is suppressed while busy; ops 1-4 and mthi/mtlo arriving while busy are dropped.
module md_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  MDUop,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        start,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] rdata
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic [31:0] hi_pend, lo_pend, hi_pend_nxt, lo_pend_nxt;
    logic [31:0] hi_nxt, lo_nxt;

    logic [63:0] prod_s, prod_u;
    logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, q_s, r_s;
    logic [31:0] b_usafe, q_u, r_u;

    assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign prod_u = {32'd0, A} * {32'd0, B};

    // Signed divide on magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0 without a special case.
    assign a_mag   = A[31] ? (~A + 32'd1) : A;
    assign b_mag   = B[31] ? (~B + 32'd1) : B;
    assign b_safe  = (b_mag == 32'd0) ? 32'd1 : b_mag;
    assign q_mag   = a_mag / b_safe;
    assign r_mag   = a_mag % b_safe;
    assign q_s     = (A[31] ^ B[31]) ? (~q_mag + 32'd1) : q_mag;
    assign r_s     = A[31] ? (~r_mag + 32'd1) : r_mag;
    assign b_usafe = (B == 32'd0) ? 32'd1 : B;
    assign q_u     = A / b_usafe;
    assign r_u     = A % b_usafe;

    assign busy  = (state == RUN);
    assign start = !busy && (MDUop >= OP_MULT) && (MDUop <= OP_DIVU);

    always_comb begin
        rdata = 32'd0;
        if (MDUop == OP_MFHI)
            rdata = HI;
        else if (MDUop == OP_MFLO)
            rdata = LO;
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        hi_pend_nxt = hi_pend;
        lo_pend_nxt = lo_pend;
        hi_nxt      = HI;
        lo_nxt      = LO;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                    cnt_nxt   = (MDUop == OP_DIV || MDUop == OP_DIVU) ? DIV_N : MULT_N;
                    case (MDUop)
                        OP_MULT:  {hi_pend_nxt, lo_pend_nxt} = prod_s;
                        OP_MULTU: {hi_pend_nxt, lo_pend_nxt} = prod_u;
                        OP_DIV: begin
                            // Divide by zero re-commits the current HI/LO (no mthi/mtlo can land while busy).
                            hi_pend_nxt = (B == 32'd0) ? HI : r_s;
                            lo_pend_nxt = (B == 32'd0) ? LO : q_s;
                        end
                        default: begin
                            hi_pend_nxt = (B == 32'd0) ? HI : r_u;
                            lo_pend_nxt = (B == 32'd0) ? LO : q_u;
                        end
                    endcase
                end else if (MDUop == OP_MTHI) begin
                    hi_nxt = A;
                end else if (MDUop == OP_MTLO) begin
                    lo_nxt = A;
                end
            end
            RUN: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt <= 4'd1) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 4'd0;
                    hi_nxt    = hi_pend;
                    lo_nxt    = lo_pend;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            hi_pend <= 32'd0;
            lo_pend <= 32'd0;
            HI      <= 32'd0;
            LO      <= 32'd0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            hi_pend <= hi_pend_nxt;
            lo_pend <= lo_pend_nxt;
            HI      <= hi_nxt;
            LO      <= lo_nxt;
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Drives two md_unit instances (default 5/10 cycles and 1/1 cycles) with directed and random ops,
// comparing every output each cycle against a timestamp-based reference model.
module tb_md_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  op;
    logic [31:0] a, b;
    logic        st [2];
    logic        bz [2];
    logic [31:0] hi [2];
    logic [31:0] lo [2];
    logic [31:0] rd [2];

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut0 (
        .clk(clk), .reset(reset), .MDUop(op), .A(a), .B(b),
        .start(st[0]), .busy(bz[0]), .HI(hi[0]), .LO(lo[0]), .rdata(rd[0]));

    md_unit #(.MULT_CYCLES(1), .DIV_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .MDUop(op), .A(a), .B(b),
        .start(st[1]), .busy(bz[1]), .HI(hi[1]), .LO(lo[1]), .rdata(rd[1]));

    always #5 clk = ~clk;

    int n_err = 0;
    int n_chk = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: an op launched in cycle c keeps the unit busy through cycle c+N.
    int unsigned nm [2] = '{5, 1};
    int unsigned nd [2] = '{10, 1};
    logic [31:0] m_hi [2];
    logic [31:0] m_lo [2];
    logic [31:0] p_hi [2];
    logic [31:0] p_lo [2];
    longint      done_at [2];
    longint      cyc;

    function automatic void model_result(input logic [3:0] o, input logic [31:0] av, input logic [31:0] bv,
                                         input logic [31:0] ohi, input logic [31:0] olo,
                                         output logic [31:0] rh, output logic [31:0] rl);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = $signed(av);
        sb = $signed(bv);
        ua = longint'({32'd0, av});
        ub = longint'({32'd0, bv});
        rh = ohi;
        rl = olo;
        case (o)
            4'd1: begin p = 64'(sa * sb); rh = p[63:32]; rl = p[31:0]; end
            4'd2: begin p = 64'(ua * ub); rh = p[63:32]; rl = p[31:0]; end
            4'd3: if (bv != 0) begin rl = 32'(sa / sb); rh = 32'(sa % sb); end
            4'd4: if (bv != 0) begin rl = 32'(ua / ub); rh = 32'(ua % ub); end
            default: ;
        endcase
    endfunction

    function automatic logic m_busy(input int i);
        return cyc <= done_at[i];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_hi[i] = 0; m_lo[i] = 0; p_hi[i] = 0; p_lo[i] = 0; done_at[i] = -1;
        end
    endtask

    task automatic step(input logic [3:0] o, input logic [31:0] av, input logic [31:0] bv);
        logic exp_start;
        logic [31:0] exp_rd;
        op = o; a = av; b = bv;
        #1;
        for (int i = 0; i < 2; i++) begin
            exp_start = (o >= 1 && o <= 4) && !m_busy(i);
            exp_rd = (o == 5) ? m_hi[i] : (o == 6) ? m_lo[i] : 32'd0;
            check($sformatf("start%0d", i), 32'(st[i]), 32'(exp_start));
            check($sformatf("busy%0d", i), 32'(bz[i]), 32'(m_busy(i)));
            check($sformatf("hi%0d", i), hi[i], m_hi[i]);
            check($sformatf("lo%0d", i), lo[i], m_lo[i]);
            check($sformatf("rdata%0d", i), rd[i], exp_rd);
        end
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (!m_busy(i) && o >= 1 && o <= 4) begin
                model_result(o, av, bv, m_hi[i], m_lo[i], p_hi[i], p_lo[i]);
                done_at[i] = cyc + longint'((o >= 3) ? nd[i] : nm[i]);
            end else if (m_busy(i)) begin
                if (cyc == done_at[i]) begin
                    m_hi[i] = p_hi[i];
                    m_lo[i] = p_lo[i];
                end
            end else if (o == 7) begin
                m_hi[i] = av;
            end else if (o == 8) begin
                m_lo[i] = av;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(4'd0, $urandom, $urandom);
    endtask

    // Asynchronous reset pulse raised mid-cycle; outputs must clear before the next edge.
    task automatic mid_reset();
        reset = 1'b1;
        #1;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst_busy%0d", i), 32'(bz[i]), 32'd0);
            check($sformatf("rst_hi%0d", i), hi[i], 32'd0);
            check($sformatf("rst_lo%0d", i), lo[i], 32'd0);
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic logic [31:0] rand_operand();
        logic [31:0] sp [6] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h2};
        if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 5)];
        return $urandom;
    endfunction

    initial begin
        reset = 1'b1; op = 4'd0; a = 32'd0; b = 32'd0;
        model_reset();
        cyc = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset state, then signed mult -1 * 2
        step(4'd1, 32'hFFFFFFFF, 32'd2);
        idle(5);
        check("mult_hi", hi[0], 32'hFFFFFFFF);
        check("mult_lo", lo[0], 32'hFFFFFFFE);
        step(4'd5, 32'd0, 32'd0);

        step(4'd2, 32'hFFFFFFFF, 32'd2);
        idle(5);
        check("multu_hi", hi[0], 32'h00000001);
        check("multu_lo", lo[0], 32'hFFFFFFFE);

        step(4'd3, 32'hFFFFFFF9, 32'd2);
        idle(10);
        check("div_lo", lo[0], 32'hFFFFFFFD);
        check("div_hi", hi[0], 32'hFFFFFFFF);

        step(4'd4, 32'd7, 32'd2);
        idle(10);
        check("divu_lo", lo[0], 32'd3);
        check("divu_hi", hi[0], 32'd1);

        step(4'd3, 32'h80000000, 32'hFFFFFFFF);
        idle(10);
        check("ovf_lo", lo[0], 32'h80000000);
        check("ovf_hi", hi[0], 32'd0);

        // Divide by zero keeps HI/LO
        step(4'd8, 32'd0, 32'd0);
        step(4'd7, 32'h12345678, 32'd0);
        step(4'd3, 32'd99, 32'd0);
        idle(10);
        check("dz_hi", hi[0], 32'h12345678);
        step(4'd6, 32'd0, 32'd0);
        check("dz_mflo", rd[0], 32'd0);

        // mthi forwarding to the next cycle's mfhi
        step(4'd7, 32'hAA, 32'd0);
        step(4'd5, 32'd0, 32'd0);
        check("mthi_fwd", rd[0], 32'hAA);

        // mtlo and mult while busy are ignored
        step(4'd1, 32'd5, 32'd6);
        step(4'd8, 32'hDEAD, 32'd0);
        step(4'd1, 32'd7, 32'd7);
        idle(3);
        check("busy_ign_lo", lo[0], 32'd30);
        check("busy_ign_bz", 32'(bz[0]), 32'd0);

        // Reset during a mult aborts it
        step(4'd1, 32'd3, 32'd4);
        idle(2);
        mid_reset();
        idle(8);
        check("abort_lo", lo[0], 32'd0);

        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 149) == 0)
                mid_reset();
            else
                step(($urandom_range(0, 7) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8)),
                     rand_operand(), rand_operand());
        end
        idle(12);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/md_unit.md
# md_unit

Multiply/divide unit in the E stage of the P6 pipeline, and the execution end of the `MDUop` code that the decoder emits. It accepts `mult/multu/div/divu` from E and runs them as multi-cycle operations while holding a busy flag. It also serves `mthi/mtlo` writes and `mfhi/mflo` reads of the architectural HI/LO registers. The hazard unit stalls the D stage on `start | busy` whenever D holds an md/mf/mt instruction.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for `mult`/`multu`; legal range 1–15.
- `DIV_CYCLES`, default 10: busy cycles for `div`/`divu`; legal range 1–15.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  reset; one clock; asynchronous, active-high.
- `MDUop`  in  4  E-stage op code: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9–15 treated as none.
- `A`  in  32  forwarded rs value.
- `B`  in  32  forwarded rt value.
- `start`  out  1  combinational; 1 iff `MDUop` is 1–4 and `busy`=0.
- `busy`  out  1  registered; 1 while an operation is in flight.
- `HI`  out  32  architectural HI register.
- `LO`  out  32  architectural LO register.
- `rdata`  out  32  combinational; `HI` when `MDUop`=5, `LO` when `MDUop`=6, else 0.

## Operation
- Registers: `HI`, `LO`, `hi_pend`, `lo_pend`, 4-bit `cnt`, `busy`.
- Two-state FSM:
  - IDLE (`busy`=0) → RUN (`busy`=1) on a clock edge with `start`=1.
  - RUN → IDLE on the edge where `cnt`=1.
- Launch. On the `start` edge:
  - `{hi_pend, lo_pend}` are loaded with the full result computed from `A` and `B` in that cycle.
  - `cnt` is loaded with `MULT_CYCLES` or `DIV_CYCLES`.
  - `A` and `B` are never sampled again for that operation.
- Result rules:
  - `mult`: 64-bit signed product, HI = upper 32 bits, LO = lower 32 bits.
  - `multu`: same split, unsigned product.
  - `div`: LO = signed quotient truncated toward zero; HI = remainder, carrying the sign of the dividend.
  - Signed overflow case 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
  - `divu`: LO = unsigned quotient, HI = unsigned remainder.
  - Divide by zero (`div` or `divu`): HI/LO unchanged at commit, but the unit still stays busy for `DIV_CYCLES`.
- RUN: `cnt` decrements each edge. On the edge where `cnt`=1, `HI`←`hi_pend`, `LO`←`lo_pend`, and `busy`←0.
- `mthi`/`mtlo` (op 7/8) with `busy`=0: `HI`←`A` or `LO`←`A` on that edge. The other register is unchanged.
- While `busy`=1:
  - ops 1–4 and 7–8 are ignored, with no state change.
  - `rdata` still returns the current (old) `HI`/`LO`.
  - The pipeline guarantees none of these occur; the ignore behaviour is defined only for robustness.
- `mfhi`/`mflo` have no side effects.

## Timing
- Reset:
  - `HI`, `LO`, `hi_pend`, `lo_pend` = 0; `cnt` = 0; `busy` = 0.
  - `start` and `rdata` follow directly from `MDUop`.
- Reset asserted mid-operation aborts the operation immediately (asynchronously). The pending result is discarded and HI/LO read 0.
- Latency for a launch in cycle 0 with parameter N:
  - `busy`=1 in cycles 1..N.
  - `busy`=0 and the new HI/LO are visible in cycle N+1.
  - `mfhi` issued in E in cycle N+1 returns the new value.
- Back-to-back operations: a new op can launch in cycle N+1, giving start-to-start spacing of N+1.
- `start` is never asserted in the same cycle as `busy`=1.
- `mthi` in cycle k: `HI` changes at the end of cycle k. `mfhi` in cycle k returns the old value; `mfhi` in cycle k+1 returns the new value.
- Parameter value 1: `busy` high for exactly one cycle.

## Test plan
- Reset, then `mult` with A=0xFFFFFFFF, B=2 → `busy` high for cycles 1–5; in cycle 6, HI=0xFFFFFFFF and LO=0xFFFFFFFE; HI/LO still 0 during cycles 1–5.
- `multu` with A=0xFFFFFFFF, B=2 → after 5 busy cycles, HI=0x00000001, LO=0xFFFFFFFE.
- Division results, each with exactly 10 busy cycles:
  - `div` A=0xFFFFFFF9 (−7), B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - `divu` A=7, B=2 → LO=3, HI=1.
  - `div` 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- `mthi` A=0x12345678, then `div` by B=0 → 10 busy cycles, HI stays 0x12345678, LO stays 0; `mflo` afterwards returns `rdata`=0.
- Hazard and forwarding checks:
  - `mthi` A=0xAA in cycle k, `mfhi` in cycle k+1 → `rdata`=0xAA.
  - `mtlo` injected while busy → LO unaffected.
  - `mult` presented while busy → `start`=0 and no relaunch.
- Reset mid-operation: `mult` A=3, B=4, with `reset` pulsed in cycle 3 → `busy` drops immediately; HI=LO=0; no later commit of 12.
